// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared types and constants for the parking gate controller.
//               Holds the gate FSM state encoding, the default counter width
//               and the vehicle class indices.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    // Gate sequencer states: waiting for requests, gate held open for a
    // passage, or a single idle-gate cycle after a deny / exit error.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 8;

    localparam int CLS_CAR  = 0;
    localparam int CLS_BIKE = 1;

endpackage
`default_nettype wire

// File: rtl/parking_class_counter.sv
`default_nettype none
// ============================================================================
// Module      : parking_class_counter
// Description : Occupancy and lifetime-entry bookkeeping for one vehicle
//               class. Occupancy is bounded to [0, CAP]; the lifetime entry
//               count saturates at all-ones. full/empty are registered from
//               the next-state occupancy so they line up with the ack.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               inc_i            - a granted entry for this class
//               dec_i            - a granted exit for this class
//               occupancy_o      - vehicles currently parked
//               total_entered_o  - lifetime granted entries (saturating)
//               full_o, empty_o  - occupancy == CAP, occupancy == 0
// Revision    : 1.0 - initial release
// ============================================================================
module parking_class_counter
    import parking_pkg::*;
#(
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] CAP   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] occupancy_o,
    output logic [CNT_W-1:0] total_entered_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             full_q, empty_q;

    // The arbiter never asks for an increment on a full class or a decrement
    // on an empty one; the bounds are still enforced here so the counter can
    // never wrap whatever the caller does.
    always_comb begin
        occ_d = occ_q;
        tot_d = tot_q;
        if (inc_i && (occ_q != CAP)) begin
            occ_d = occ_q + CNT_W'(1);
            if (tot_q != '1) begin
                tot_d = tot_q + CNT_W'(1);
            end
        end else if (dec_i && (occ_q != '0)) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            tot_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            tot_q   <= tot_d;
            full_q  <= (occ_d == CAP);
            empty_q <= (occ_d == '0);
        end
    end

    assign occupancy_o     = occ_q;
    assign total_entered_o = tot_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;

endmodule
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller
// Description : Multi-class parking gate controller. Arbitrates per-class
//               entry/exit requests onto one shared gate (exits first, lowest
//               class wins; entries round-robin), keeps per-class occupancy
//               and lifetime entry counts, and drives the gate for a fixed
//               number of cycles per granted passage.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               entry_req      - per-class entry request (level)
//               exit_req       - per-class exit request (level)
//               entry_ack      - entry granted pulse
//               exit_ack       - exit granted pulse
//               deny           - entry refused (class full) pulse
//               exit_err       - exit from an empty class pulse
//               gate_open      - gate actuator drive
//               busy           - sequencer not idle
//               occupancy      - packed per-class occupancy
//               total_entered  - packed per-class lifetime entries
//               full, empty    - per-class occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int                           NUM_CLASSES = 2,
    parameter int                           CNT_W       = DEF_CNT_W,
    parameter logic [NUM_CLASSES*CNT_W-1:0] CAP_VEC     = {8'd6, 8'd4},
    parameter int                           GATE_CYCLES = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CLASSES-1:0]         entry_req,
    input  logic [NUM_CLASSES-1:0]         exit_req,
    output logic [NUM_CLASSES-1:0]         entry_ack,
    output logic [NUM_CLASSES-1:0]         exit_ack,
    output logic [NUM_CLASSES-1:0]         deny,
    output logic [NUM_CLASSES-1:0]         exit_err,
    output logic                           gate_open,
    output logic                           busy,
    output logic [NUM_CLASSES*CNT_W-1:0]   occupancy,
    output logic [NUM_CLASSES*CNT_W-1:0]   total_entered,
    output logic [NUM_CLASSES-1:0]         full,
    output logic [NUM_CLASSES-1:0]         empty
);

    localparam int PW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int GW = $clog2(GATE_CYCLES);

    state_t                 state_q, state_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic [NUM_CLASSES-1:0] entry_ack_q, entry_ack_d;
    logic [NUM_CLASSES-1:0] exit_ack_q, exit_ack_d;
    logic [NUM_CLASSES-1:0] deny_q, deny_d;
    logic [NUM_CLASSES-1:0] exit_err_q, exit_err_d;
    logic                   gate_q, gate_d;
    logic                   busy_q, busy_d;

    logic [NUM_CLASSES-1:0] inc_w, dec_w;
    logic [NUM_CLASSES-1:0] full_w, empty_w;

    logic                   found_w;
    int                     win_w;
    int                     idx_w;

    always_comb begin
        state_d     = state_q;
        gcnt_d      = gcnt_q;
        rr_d        = rr_q;
        entry_ack_d = '0;
        exit_ack_d  = '0;
        deny_d      = '0;
        exit_err_d  = '0;
        gate_d      = 1'b0;
        inc_w       = '0;
        dec_w       = '0;
        found_w     = 1'b0;
        win_w       = 0;
        idx_w       = 0;

        case (state_q)
            ST_IDLE: begin
                // Exits have absolute priority; lowest class index wins.
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (!found_w && exit_req[i]) begin
                        found_w = 1'b1;
                        win_w   = i;
                    end
                end
                if (found_w) begin
                    if (empty_w[win_w]) begin
                        exit_err_d[win_w] = 1'b1;
                        state_d           = ST_HOLD;
                    end else begin
                        exit_ack_d[win_w] = 1'b1;
                        dec_w[win_w]      = 1'b1;
                        gate_d            = 1'b1;
                        gcnt_d            = GW'(GATE_CYCLES - 1);
                        state_d           = ST_OPEN;
                    end
                end else begin
                    // Round-robin entry search starting at the pointer.
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        idx_w = (int'(rr_q) + k) % NUM_CLASSES;
                        if (!found_w && entry_req[idx_w]) begin
                            found_w = 1'b1;
                            win_w   = idx_w;
                        end
                    end
                    if (found_w) begin
                        rr_d = PW'((win_w + 1) % NUM_CLASSES);
                        if (full_w[win_w]) begin
                            deny_d[win_w] = 1'b1;
                            state_d       = ST_HOLD;
                        end else begin
                            entry_ack_d[win_w] = 1'b1;
                            inc_w[win_w]       = 1'b1;
                            gate_d             = 1'b1;
                            gcnt_d             = GW'(GATE_CYCLES - 1);
                            state_d            = ST_OPEN;
                        end
                    end
                end
            end

            // gcnt counts the open cycles still to follow the current one.
            ST_OPEN: begin
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                    gate_d = 1'b1;
                end
            end

            ST_HOLD: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gcnt_q      <= '0;
            rr_q        <= '0;
            entry_ack_q <= '0;
            exit_ack_q  <= '0;
            deny_q      <= '0;
            exit_err_q  <= '0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            rr_q        <= rr_d;
            entry_ack_q <= entry_ack_d;
            exit_ack_q  <= exit_ack_d;
            deny_q      <= deny_d;
            exit_err_q  <= exit_err_d;
            gate_q      <= gate_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
        parking_class_counter #(
            .CNT_W (CNT_W),
            .CAP   (CAP_VEC[gi*CNT_W +: CNT_W])
        ) u_counter (
            .clk             (clk),
            .rst             (rst),
            .inc_i           (inc_w[gi]),
            .dec_i           (dec_w[gi]),
            .occupancy_o     (occupancy[gi*CNT_W +: CNT_W]),
            .total_entered_o (total_entered[gi*CNT_W +: CNT_W]),
            .full_o          (full_w[gi]),
            .empty_o         (empty_w[gi])
        );
    end

    assign entry_ack = entry_ack_q;
    assign exit_ack  = exit_ack_q;
    assign deny      = deny_q;
    assign exit_err  = exit_err_q;
    assign gate_open = gate_q;
    assign busy      = busy_q;
    assign full      = full_w;
    assign empty     = empty_w;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_controller
// Description : Self-checking bench for parking_gate_controller. A
//               transaction/time-based reference model predicts every
//               output each cycle; directed scenarios add literal checks;
//               a second instance with 3-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

    localparam int N = 2;
    localparam int W = 8;
    localparam int G = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   entry_req, exit_req;
    logic [N-1:0]   entry_ack, exit_ack, deny, exit_err, full, empty;
    logic           gate_open, busy;
    logic [N*W-1:0] occupancy, total_entered;

    // Small-counter instance for saturation
    logic [1:0] e2_req, x2_req, e2_ack, x2_ack, deny2, xerr2, full2, empty2;
    logic       gate2, busy2;
    logic [5:0] occ2, tot2;

    always #5 clk = ~clk;

    parking_gate_controller #(
        .NUM_CLASSES (N),
        .CNT_W       (W),
        .CAP_VEC     ({8'd6, 8'd4}),
        .GATE_CYCLES (G)
    ) dut (
        .clk (clk), .rst (rst),
        .entry_req (entry_req), .exit_req (exit_req),
        .entry_ack (entry_ack), .exit_ack (exit_ack),
        .deny (deny), .exit_err (exit_err),
        .gate_open (gate_open), .busy (busy),
        .occupancy (occupancy), .total_entered (total_entered),
        .full (full), .empty (empty)
    );

    parking_gate_controller #(
        .NUM_CLASSES (2),
        .CNT_W       (3),
        .CAP_VEC     ({3'd7, 3'd7}),
        .GATE_CYCLES (2)
    ) dut_sat (
        .clk (clk), .rst (rst),
        .entry_req (e2_req), .exit_req (x2_req),
        .entry_ack (e2_ack), .exit_ack (x2_ack),
        .deny (deny2), .exit_err (xerr2),
        .gate_open (gate2), .busy (busy2),
        .occupancy (occ2), .total_entered (tot2),
        .full (full2), .empty (empty2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks when the gate is next free (edge number),
    // when the gate window ends, and plain integer counts per class.
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         m_cap [N] = '{4, 6};
    int         m_occ [N];
    int         m_tot [N];
    int         m_ptr = 0;
    int         m_free = 0;
    int         m_gate_end = 0;
    logic [N-1:0] m_eack = '0, m_xack = '0, m_deny = '0, m_xerr = '0;
    logic       m_gate = 1'b0, m_busy = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        int  e;
        bit  fnd;
        int  idx;
        e      = cyc;
        m_eack = '0;
        m_xack = '0;
        m_deny = '0;
        m_xerr = '0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_occ[i] = 0;
                m_tot[i] = 0;
            end
            m_ptr      = 0;
            m_free     = e + 1;
            m_gate_end = e;
        end else if (e >= m_free) begin
            fnd = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!fnd && exit_req[i]) begin
                    fnd = 1'b1;
                    if (m_occ[i] == 0) begin
                        m_xerr[i] = 1'b1;
                        m_free    = e + 2;
                    end else begin
                        m_occ[i]   = m_occ[i] - 1;
                        m_xack[i]  = 1'b1;
                        m_free     = e + G + 1;
                        m_gate_end = e + G;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!fnd && entry_req[idx]) begin
                    fnd   = 1'b1;
                    m_ptr = (idx + 1) % N;
                    if (m_occ[idx] == m_cap[idx]) begin
                        m_deny[idx] = 1'b1;
                        m_free      = e + 2;
                    end else begin
                        m_occ[idx]  = m_occ[idx] + 1;
                        m_tot[idx]  = (m_tot[idx] >= 255) ? 255 : m_tot[idx] + 1;
                        m_eack[idx] = 1'b1;
                        m_free      = e + G + 1;
                        m_gate_end  = e + G;
                    end
                end
            end
        end
        m_gate = (e < m_gate_end);
        m_busy = (e < m_free - 1);
        cyc    = cyc + 1;
    end

    always @(negedge clk) begin : compare
        logic [N*W-1:0] eo, et;
        logic [N-1:0]   ef, ee;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                eo[i*W +: W] = W'(m_occ[i]);
                et[i*W +: W] = W'(m_tot[i]);
                ef[i]        = (m_occ[i] == m_cap[i]);
                ee[i]        = (m_occ[i] == 0);
            end
            chk("entry_ack", 32'(entry_ack), 32'(m_eack));
            chk("exit_ack",  32'(exit_ack),  32'(m_xack));
            chk("deny",      32'(deny),      32'(m_deny));
            chk("exit_err",  32'(exit_err),  32'(m_xerr));
            chk("gate_open", 32'(gate_open), 32'(m_gate));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("occupancy", 32'(occupancy), 32'(eo));
            chk("total",     32'(total_entered), 32'(et));
            chk("full",      32'(full),      32'(ef));
            chk("empty",     32'(empty),     32'(ee));
        end
    end

    // ------------------------------------------------------------------
    // Requester behaviour and event accounting
    // ------------------------------------------------------------------
    int eack_cnt [N];
    int deny_cnt [N];
    int xack_cnt [N];
    int xerr_cnt [N];
    int gate_cnt;
    int busy_cnt;
    int ev_q [$];

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            eack_cnt[i] = 0;
            deny_cnt[i] = 0;
            xack_cnt[i] = 0;
            xerr_cnt[i] = 0;
        end
        gate_cnt = 0;
        busy_cnt = 0;
        ev_q.delete();
    endtask

    // Advance to the next negedge, record responses and drop answered reqs.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (entry_ack[i]) begin eack_cnt[i]++; ev_q.push_back(i*4 + 0); end
            if (deny[i])      begin deny_cnt[i]++; ev_q.push_back(i*4 + 1); end
            if (exit_ack[i])  begin xack_cnt[i]++; ev_q.push_back(i*4 + 2); end
            if (exit_err[i])  begin xerr_cnt[i]++; ev_q.push_back(i*4 + 3); end
        end
        if (gate_open) gate_cnt++;
        if (busy)      busy_cnt++;
        entry_req = entry_req & ~(entry_ack | deny);
        exit_req  = exit_req  & ~(exit_ack  | exit_err);
        e2_req    = e2_req & ~(e2_ack | deny2);
        x2_req    = x2_req & ~(x2_ack | xerr2);
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int k;
        k = 0;
        while (((entry_req | exit_req | e2_req | x2_req) != '0) && (k < bound)) begin
            step();
            k++;
        end
        chk(nm, 32'(entry_req | exit_req | e2_req | x2_req), 32'd0);
        repeat (G + 2) step();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        rst       = 1'b1;
        entry_req = '0;
        exit_req  = '0;
        e2_req    = '0;
        x2_req    = '0;
        clr_counts();

        // 1. Reset state
        step();
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_total", 32'(total_entered), 32'd0);
        chk("rst_empty", 32'(empty), 32'd3);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_gate",  32'(gate_open), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;
        step();

        // 2. Five car entries
        clr_counts();
        for (int n = 0; n < 5; n++) begin
            entry_req[0] = 1'b1;
            wait_idle("car_entry_timeout", 20);
        end
        chk("car_acks",  32'(eack_cnt[0]), 32'd4);
        chk("car_deny",  32'(deny_cnt[0]), 32'd1);
        chk("car_gate_cycles", 32'(gate_cnt), 32'd12);
        chk("car_occ",   32'(occupancy[7:0]), 32'd4);
        chk("car_total", 32'(total_entered[7:0]), 32'd4);
        chk("car_full",  32'(full[0]), 32'd1);

        // 3. Seven bike entries, two car exits, three bike exits
        clr_counts();
        for (int n = 0; n < 7; n++) begin
            entry_req[1] = 1'b1;
            wait_idle("bike_entry_timeout", 20);
        end
        for (int n = 0; n < 2; n++) begin
            exit_req[0] = 1'b1;
            wait_idle("car_exit_timeout", 20);
        end
        for (int n = 0; n < 3; n++) begin
            exit_req[1] = 1'b1;
            wait_idle("bike_exit_timeout", 20);
        end
        chk("bike_acks", 32'(eack_cnt[1]), 32'd6);
        chk("bike_deny", 32'(deny_cnt[1]), 32'd1);
        chk("mix_occ",   32'(occupancy), 32'h0302);
        chk("mix_total", 32'(total_entered), 32'h0604);

        // 4. Exit from an empty bike class
        for (int n = 0; n < 3; n++) begin
            exit_req[1] = 1'b1;
            wait_idle("bike_drain_timeout", 20);
        end
        clr_counts();
        exit_req[1] = 1'b1;
        wait_idle("exit_err_timeout", 20);
        chk("err_pulses", 32'(xerr_cnt[1]), 32'd1);
        chk("err_gate",   32'(gate_cnt), 32'd0);
        chk("err_busy",   32'(busy_cnt), 32'd1);
        chk("err_occ",    32'(occupancy), 32'h0002);

        // 5. Simultaneous requests: exit 1, then entry 0, then entry 1
        clr_counts();
        entry_req = 2'b11;
        exit_req  = 2'b10;
        wait_idle("multi_timeout", 40);
        chk("order_len", 32'(ev_q.size()), 32'd3);
        if (ev_q.size() == 3) begin
            chk("order_0", 32'(ev_q[0]), 32'd7);
            chk("order_1", 32'(ev_q[1]), 32'd0);
            chk("order_2", 32'(ev_q[2]), 32'd4);
        end
        chk("multi_gate_cycles", 32'(gate_cnt), 32'd6);

        // 6. Reset during the second OPEN cycle, pending request survives
        entry_req = 2'b11;
        k = 0;
        while (entry_req[0] && k < 20) begin
            step();
            k++;
        end
        chk("mid_open_ack", 32'(entry_req[0]), 32'd0);
        step();
        chk("mid_open_gate", 32'(gate_open), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_gate",  32'(gate_open), 32'd0);
        chk("mid_rst_occ",   32'(occupancy), 32'd0);
        chk("mid_rst_total", 32'(total_entered), 32'd0);
        rst = 1'b0;
        wait_idle("post_rst_timeout", 20);
        chk("post_rst_occ",   32'(occupancy), 32'h0100);
        chk("post_rst_total", 32'(total_entered), 32'h0100);

        // Randomised traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!entry_req[i] && ($urandom_range(0, 3) == 0)) entry_req[i] = 1'b1;
                if (!exit_req[i]  && ($urandom_range(0, 5) == 0)) exit_req[i]  = 1'b1;
            end
        end
        rst = 1'b0;
        wait_idle("random_drain_timeout", 200);

        // Saturation with 3-bit counters, capacity 7
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 9; n++) begin
            e2_req[0] = 1'b1;
            wait_idle("sat_entry_timeout", 20);
            x2_req[0] = 1'b1;
            wait_idle("sat_exit_timeout", 20);
            if (n == 2) chk("sat_total_3", 32'(tot2[2:0]), 32'd3);
        end
        chk("sat_total", 32'(tot2[2:0]), 32'd7);
        chk("sat_occ",   32'(occ2), 32'd0);
        chk("sat_empty", 32'(empty2), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
